// File: rtl/counter_display_ndigit_if.sv
// Bundle of the counter control inputs and display/count outputs of
// counter_display_ndigit. clk and reset_n stay plain ports on the module.
//   master : board-side driver (drives controls, observes count/display)
//   slave  : counter_display_ndigit itself
// Signals:
//   enable, up_down, mode_bcd, load, load_value[W], blank_lz, dp_mask[N] -> slave
//   value[W], wrap, segments[8], digitselect[N]                          <- slave
interface counter_display_ndigit_if #(
  parameter int NDIGITS = 8
);
  localparam int W = 4 * NDIGITS;

  logic               enable;
  logic               up_down;
  logic               mode_bcd;
  logic               load;
  logic [W-1:0]       load_value;
  logic               blank_lz;
  logic [NDIGITS-1:0] dp_mask;
  logic [W-1:0]       value;
  logic               wrap;
  logic [7:0]         segments;
  logic [NDIGITS-1:0] digitselect;

  modport master (
    output enable, up_down, mode_bcd, load, load_value, blank_lz, dp_mask,
    input  value, wrap, segments, digitselect
  );

  modport slave (
    input  enable, up_down, mode_bcd, load, load_value, blank_lz, dp_mask,
    output value, wrap, segments, digitselect
  );
endinterface

// File: rtl/counter_display_ndigit.sv
// N-digit up/down counter (hex or BCD) advanced by a prescaler tick, with
// synchronous load, driving a time-multiplexed common-anode 7-segment display
// with leading-zero blanking and per-digit decimal points.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : counter_display_ndigit_if.slave (controls in; value, wrap,
//              segments {dp,g..a} active low, digitselect active low out)
module counter_display_ndigit #(
  parameter int NDIGITS     = 8,
  parameter int PRESCALE    = 50000000,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  counter_display_ndigit_if.slave  bus
);

  localparam int W  = 4 * NDIGITS;
  localparam int PW = (PRESCALE    > 1) ? $clog2(PRESCALE)    : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NDIGITS     > 1) ? $clog2(NDIGITS)     : 1;

  logic [W-1:0]       value_q, value_d;
  logic               wrap_q, wrap_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               mode_q;
  logic [RW-1:0]      ref_q, ref_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         seg_q, seg_d;
  logic [NDIGITS-1:0] dsel_q, dsel_d;

  logic               tick;
  logic [W-1:0]       hex_next, bcd_next, load_sat;
  logic               hex_wrap, bcd_wrap, bcd_c;
  logic [3:0]         bcd_nib, ld_nib, disp_nib;
  logic               blank;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign tick = (presc_q == PW'(PRESCALE - 1));

  // Hex step: the extra top bit is the carry/borrow out, i.e. the wrap flag.
  always_comb begin
    if (bus.up_down) {hex_wrap, hex_next} = {1'b0, value_q} + (W+1)'(1);
    else             {hex_wrap, hex_next} = {1'b0, value_q} - (W+1)'(1);
  end

  // BCD step: ripple a carry/borrow digit by digit; surviving carry = wrap.
  always_comb begin
    bcd_next = value_q;
    bcd_c    = 1'b1;
    bcd_nib  = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      bcd_nib = value_q[4*i +: 4];
      if (bcd_c) begin
        if (bus.up_down) begin
          if (bcd_nib >= 4'd9) bcd_nib = 4'd0;
          else begin bcd_nib = bcd_nib + 4'd1; bcd_c = 1'b0; end
        end else begin
          if (bcd_nib == 4'd0) bcd_nib = 4'd9;
          else begin bcd_nib = bcd_nib - 4'd1; bcd_c = 1'b0; end
        end
      end
      bcd_next[4*i +: 4] = bcd_nib;
    end
    bcd_wrap = bcd_c;
  end

  always_comb begin
    load_sat = '0;
    ld_nib   = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      ld_nib = bus.load_value[4*i +: 4];
      load_sat[4*i +: 4] = (ld_nib > 4'd9) ? 4'd9 : ld_nib;
    end
  end

  // Counter priority: mode change, then load, then prescaler tick.
  always_comb begin
    value_d = value_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (bus.mode_bcd != mode_q) begin
      value_d = '0;
      presc_d = '0;
    end else if (bus.load) begin
      value_d = mode_q ? load_sat : bus.load_value;
      presc_d = '0;
    end else if (bus.enable) begin
      if (tick) begin
        presc_d = '0;
        value_d = mode_q ? bcd_next : hex_next;
        wrap_d  = mode_q ? bcd_wrap : hex_wrap;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Display scan, independent of enable/load.
  always_comb begin
    ref_d = ref_q + RW'(1);
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Blank when this digit and every more significant one are zero.
  always_comb begin
    disp_nib = value_q[{idx_q, 2'b00} +: 4];
    blank    = bus.blank_lz && (idx_q != '0) && ((value_q >> {idx_q, 2'b00}) == '0);
    seg_d    = {~bus.dp_mask[idx_q], blank ? 7'h7F : seg7(disp_nib)};
    dsel_d   = ~(NDIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
      presc_q <= '0;
      mode_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '1;
      dsel_q  <= '1;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
      mode_q  <= bus.mode_bcd;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dsel_q  <= dsel_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.wrap        = wrap_q;
  assign bus.segments    = seg_q;
  assign bus.digitselect = dsel_q;

endmodule

// File: tb/tb_counter_display_ndigit.sv
module tb_counter_display_ndigit;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  counter_display_ndigit_if #(.NDIGITS(4)) bus ();

  counter_display_ndigit #(
    .NDIGITS(4),
    .PRESCALE(4),
    .REFRESH_DIV(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load = 1'b1;
    bus.load_value = v;
    step(1);
    bus.load = 1'b0;
  endtask

  initial begin
    logic found;
    logic [3:0] prev;
    reset_n        = 1'b1;
    bus.enable     = 1'b1;
    bus.up_down    = 1'b1;
    bus.mode_bcd   = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.blank_lz   = 1'b1;
    bus.dp_mask    = 4'b0010;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_value", 32'(bus.value), 32'h0);
    chk("rst_wrap", 32'(bus.wrap), 32'h0);
    chk("rst_seg", 32'(bus.segments), 32'hFF);
    chk("rst_dsel", 32'(bus.digitselect), 32'hF);
    step(2);
    reset_n = 1'b1;

    // Hex up, tick every 4 cycles
    step(3);  chk("hex_v0", 32'(bus.value), 32'h0000);
    step(1);  chk("hex_v1", 32'(bus.value), 32'h0001);
    step(4);  chk("hex_v2", 32'(bus.value), 32'h0002);

    do_load(16'hFFFF);
    chk("hex_ldFFFF", 32'(bus.value), 32'hFFFF);
    step(3);  chk("hex_prewrap", 32'(bus.value), 32'hFFFF);
    chk("hex_prewrap_w", 32'(bus.wrap), 32'h0);
    step(1);  chk("hex_wrap_v", 32'(bus.value), 32'h0000);
    chk("hex_wrap_w", 32'(bus.wrap), 32'h1);
    step(1);  chk("hex_wrap_w_off", 32'(bus.wrap), 32'h0);

    // BCD mode
    bus.mode_bcd = 1'b1;
    step(1);  chk("bcd_modechg", 32'(bus.value), 32'h0000);
    do_load(16'h0999);
    step(4);  chk("bcd_0999_up", 32'(bus.value), 32'h1000);
    do_load(16'h9999);
    step(4);  chk("bcd_9999_up", 32'(bus.value), 32'h0000);
    chk("bcd_up_wrap", 32'(bus.wrap), 32'h1);
    step(1);  chk("bcd_up_wrap_off", 32'(bus.wrap), 32'h0);
    bus.up_down = 1'b0;
    step(3);  chk("bcd_0_down", 32'(bus.value), 32'h9999);
    chk("bcd_down_wrap", 32'(bus.wrap), 32'h1);

    do_load(16'hABC5);
    chk("bcd_sat", 32'(bus.value), 32'h9995);
    bus.up_down = 1'b1;
    step(3);  // prescaler now at terminal count
    do_load(16'h1234);
    chk("ld_over_tick", 32'(bus.value), 32'h1234);
    chk("ld_over_tick_w", 32'(bus.wrap), 32'h0);
    step(3);  chk("presc_restart", 32'(bus.value), 32'h1234);
    step(1);  chk("presc_tick", 32'(bus.value), 32'h1235);

    // Mode toggle clears count without wrap
    bus.mode_bcd = 1'b0;
    step(1);
    do_load(16'h00F3);
    chk("hex_ld00F3", 32'(bus.value), 32'h00F3);
    bus.mode_bcd = 1'b1;
    step(1);  chk("toggle_value", 32'(bus.value), 32'h0000);
    chk("toggle_wrap", 32'(bus.wrap), 32'h0);

    // enable=0 freezes count and prescaler
    do_load(16'h0042);
    step(2);
    bus.enable = 1'b0;
    step(20); chk("hold_value", 32'(bus.value), 32'h0042);
    bus.enable = 1'b1;
    step(1);  chk("hold_resume1", 32'(bus.value), 32'h0042);
    step(1);  chk("hold_resume2", 32'(bus.value), 32'h0043);

    // Display scan of 0042 with blanking, dp on digit 1
    bus.enable = 1'b0;
    do_load(16'h0042);
    found = 1'b0;
    prev  = bus.digitselect;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.digitselect == 4'hE && prev != 4'hE) begin
        found = 1'b1;
        break;
      end
      prev = bus.digitselect;
    end
    chk("scan_sync", 32'(found), 32'h1);
    chk("scan_d0_sel", 32'(bus.digitselect), 32'hE);
    chk("scan_d0_seg", 32'(bus.segments), 32'hA4);
    step(1);  chk("scan_d0_hold", 32'(bus.digitselect), 32'hE);
    step(1);  chk("scan_d1_sel", 32'(bus.digitselect), 32'hD);
    chk("scan_d1_seg", 32'(bus.segments), 32'h19);
    step(2);  chk("scan_d2_sel", 32'(bus.digitselect), 32'hB);
    chk("scan_d2_seg", 32'(bus.segments), 32'hFF);
    step(2);  chk("scan_d3_sel", 32'(bus.digitselect), 32'h7);
    chk("scan_d3_seg", 32'(bus.segments), 32'hFF);
    step(2);  chk("scan_d0_again", 32'(bus.digitselect), 32'hE);
    chk("scan_d0_seg2", 32'(bus.segments), 32'hA4);

    // Asynchronous reset between edges
    bus.enable = 1'b1;
    step(1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_value", 32'(bus.value), 32'h0);
    chk("arst_seg", 32'(bus.segments), 32'hFF);
    chk("arst_dsel", 32'(bus.digitselect), 32'hF);
    chk("arst_wrap", 32'(bus.wrap), 32'h0);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("post_rst_dsel", 32'(bus.digitselect), 32'hE);
    chk("post_rst_seg", 32'(bus.segments), 32'hC0);
    chk("post_rst_value", 32'(bus.value), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
